// File: rtl/uart_pkg.sv
// uart_pkg: shared channel-ID width helper and output-stage state for the UART RX arbiter
package uart_pkg;
  typedef enum logic {EMPTY, FULL} ostate_e;
  function automatic int ch_id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter; search starts one past the last granted requester
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = ch_id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  logic [IDX_W-1:0] last_q, last_d;
  int idx;
  // Walk from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        grant = '0;
        grant[IDX_W'(idx)] = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    last_d = advance ? grant_idx : last_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) last_q <= IDX_W'(NUM_REQ - 1);
    else last_q <= last_d;
endmodule

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: merges NUM_CH UART RX byte streams into one valid/ready stream tagged by channel.
// Define UART_RX_ARBITER_OVERRUN_EN to enable sticky per-channel overrun flags and their clear.
module uart_rx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_BITS = 8,
  localparam int CH_ID_W = ch_id_width(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [NUM_CH-1:0]             i_ch_valid,
  input  logic [NUM_CH*DATA_BITS-1:0]   i_ch_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_BITS-1:0]          o_data,
  output logic [CH_ID_W-1:0]            o_ch_id,
  input  logic [NUM_CH-1:0]             i_overrun_clr,
  output logic [NUM_CH-1:0]             o_overrun
);
  ostate_e state_q, state_d;
  logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q [NUM_CH];
  logic [DATA_BITS-1:0] hold_data_d [NUM_CH];
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CH_ID_W-1:0] ch_id_q, ch_id_d;
  logic [NUM_CH-1:0] grant, take, ovr_set;
  logic [CH_ID_W-1:0] grant_idx;
  logic any, load;
  rr_arbiter #(.NUM_REQ(NUM_CH)) u_rr (
    .clk(clk),
    .n_rst(n_rst),
    .req(hold_valid_q),
    .advance(load & any),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  // A granted channel may refill in the same cycle; otherwise a full hold drops the new byte.
  always_comb begin
    any = |hold_valid_q;
    load = (state_q == EMPTY) | ((state_q == FULL) & i_ready);
    take = grant & {NUM_CH{load & any}};
    for (int k = 0; k < NUM_CH; k++) begin
      hold_valid_d[k] = i_ch_valid[k] | (hold_valid_q[k] & ~take[k]);
      hold_data_d[k] = (i_ch_valid[k] & (~hold_valid_q[k] | take[k])) ? i_ch_data[k*DATA_BITS +: DATA_BITS] : hold_data_q[k];
      ovr_set[k] = i_ch_valid[k] & hold_valid_q[k] & ~take[k];
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state_q <= EMPTY;
    else state_q <= state_d;
  always_comb begin
    state_d = load ? (any ? FULL : EMPTY) : state_q;
    data_d = (load & any) ? hold_data_q[grant_idx] : data_q;
    ch_id_d = (load & any) ? grant_idx : ch_id_q;
  end
  always_comb begin
    o_valid = (state_q == FULL);
    o_data = data_q;
    o_ch_id = ch_id_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      hold_valid_q <= '0;
      data_q <= '0;
      ch_id_q <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_data_q[k] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      data_q <= data_d;
      ch_id_q <= ch_id_d;
      for (int k = 0; k < NUM_CH; k++) hold_data_q[k] <= hold_data_d[k];
    end
`ifdef UART_RX_ARBITER_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  always_comb overrun_d = ovr_set | (overrun_q & ~i_overrun_clr);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) overrun_q <= '0;
    else overrun_q <= overrun_d;
  assign o_overrun = overrun_q;
`else
  logic unused_ovr;
  assign unused_ovr = ^{i_overrun_clr, ovr_set};
  assign o_overrun = '0;
`endif
endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb_uart_rx_arbiter: randomized + directed scoreboard bench against a queue-based reference model
module tb_uart_rx_arbiter;
  localparam int N = 4;
  logic clk = 0, n_rst = 0;
  logic [N-1:0] i_ch_valid = '0, i_overrun_clr = '0, o_overrun;
  logic [N*8-1:0] i_ch_data = '0;
  logic i_ready = 0, o_valid;
  logic [7:0] o_data;
  logic [1:0] o_ch_id;
  int checks = 0, fails = 0;
  logic [9:0] exp_q[$];
  int acc_q[$];
  bit m_full;
  int m_last;
  bit m_hv[N];
  logic [7:0] m_hd[N];
  logic [N-1:0] m_ovr;

  uart_rx_arbiter #(.NUM_CH(N), .DATA_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .i_ch_valid(i_ch_valid), .i_ch_data(i_ch_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ch_id(o_ch_id),
    .i_overrun_clr(i_overrun_clr), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    for (int i = 1; i <= N; i++) if (m_hv[(m_last + i) % N]) return (m_last + i) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_full = 0;
    m_last = N - 1;
    m_ovr = '0;
    for (int k = 0; k < N; k++) begin m_hv[k] = 0; m_hd[k] = 0; end
    exp_q.delete();
  endtask

  task automatic m_step();
    bit load;
    int g;
    load = !m_full || i_ready;
    g = m_grant();
    if (load) begin
      if (g >= 0) begin
        m_full = 1;
        exp_q.push_back({2'(g), m_hd[g]});
        m_last = g;
      end else m_full = 0;
    end
    for (int k = 0; k < N; k++) begin
      bit taken, set_o;
      taken = load && g == k;
      set_o = 0;
      if (i_ch_valid[k]) begin
        if (!m_hv[k] || taken) begin m_hd[k] = i_ch_data[k*8 +: 8]; m_hv[k] = 1; end
        else set_o = 1;
      end else if (taken) m_hv[k] = 0;
`ifdef UART_RX_ARBITER_OVERRUN_EN
      if (set_o) m_ovr[k] = 1;
      else if (i_overrun_clr[k]) m_ovr[k] = 0;
`endif
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!n_rst) m_reset();
    else m_step();
  end

  bit prev_stall = 0;
  logic [9:0] prev_out;
  initial forever begin
    @(negedge clk);
    if (!n_rst) prev_stall = 0;
    else begin
      check("o_valid", 32'(o_valid), 32'(m_full));
      check("o_overrun", 32'(o_overrun), 32'(m_ovr));
      if (prev_stall) check("stall_hold", 32'({o_valid, o_ch_id, o_data}), 32'({1'b1, prev_out}));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'({o_ch_id, o_data}), 32'h3ff);
        else check("out_byte", 32'({o_ch_id, o_data}), 32'(exp_q.pop_front()));
        acc_q.push_back(int'(o_ch_id));
      end
      prev_stall = o_valid && !i_ready;
      prev_out = {o_ch_id, o_data};
    end
  end

  task automatic cyc(input logic [N-1:0] v, input logic [31:0] d, input logic r, input logic [N-1:0] c);
    i_ch_valid = v;
    i_ch_data = d;
    i_ready = r;
    i_overrun_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_id", 32'(o_ch_id), 0);
    check("rst_ovr", 32'(o_overrun), 0);
    n_rst = 1;
    cyc(0, 0, 1, 0);
    // single byte latency
    cyc(4'b0100, 32'h00A5_0000, 1, 0);
    check("lat_t1_valid", 32'(o_valid), 0);
    cyc(0, 0, 1, 0);
    check("lat_t2_valid", 32'(o_valid), 1);
    check("lat_t2_data", 32'(o_data), 32'hA5);
    check("lat_t2_id", 32'(o_ch_id), 2);
    repeat (3) cyc(0, 0, 1, 0);
    // simultaneous
    cyc(4'hF, 32'h1312_1110, 1, 0);
    repeat (6) cyc(0, 0, 1, 0);
    // backpressure
    cyc(4'b0010, 32'h0000_5500, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'b0010, 32'h0000_6600, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    check("bp_data", 32'(o_data), 32'h55);
    repeat (4) cyc(0, 0, 1, 0);
    check("bp_ovr", 32'(o_overrun), 0);
    // overrun
    cyc(4'b0001, 32'h01, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(4'b0001, 32'h02, 0, 0);
    cyc(4'b0001, 32'h03, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
`ifdef UART_RX_ARBITER_OVERRUN_EN
    check("ovr_set", 32'(o_overrun), 1);
`else
    check("ovr_off", 32'(o_overrun), 0);
`endif
    repeat (4) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 4'b0001);
    check("ovr_clr", 32'(o_overrun), 0);
    // fairness: re-pulse a channel when its hold is free or it is being granted now
    acc_q.delete();
    for (int i = 0; i < 14; i++) begin
      v = '0;
      for (int k = 0; k < 2; k++) v[k] = !m_hv[k] || m_grant() == k;
      cyc(v, $urandom, 1, 0);
    end
    check("fair_ovr", 32'(o_overrun), 0);
    check("fair_count", 32'(acc_q.size() >= 10), 1);
    for (int i = 1; i < acc_q.size(); i++) check("fair_alt", 32'(acc_q[i]), 32'(1 - acc_q[i-1]));
    repeat (4) cyc(0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(N'($urandom & $urandom), $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0 ? N'($urandom) : '0);
    repeat (8) cyc(0, 0, 1, 4'hF);
    // reset mid-operation
    cyc(4'b0111, 32'h00_C3B2A1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    check("pre_rst_full", 32'(o_valid), 1);
    n_rst = 0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_data", 32'(o_data), 0);
    check("mid_rst_id", 32'(o_ch_id), 0);
    check("mid_rst_ovr", 32'(o_overrun), 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1;
    repeat (4) cyc(0, 0, 1, 0);
    check("post_rst_empty", 32'(o_valid), 0);
    cyc(4'b1000, 32'h7700_0000, 1, 0);
    cyc(0, 0, 1, 0);
    check("post_rst_id", 32'(o_ch_id), 3);
    check("post_rst_data", 32'(o_data), 32'h77);
    repeat (10) cyc(0, 0, 1, 0);
    check("drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_arbiter.md
# uart_rx_arbiter

Round-robin arbiter that merges the byte streams of NUM_CH independent UART receivers into a single valid/ready byte stream tagged with the source channel. Each receiver's single-cycle data-valid pulse is captured into a per-channel one-byte holding register. A rotating-priority grant then moves held bytes into a registered output stage. It sits between the bank of UART RX instances and the single downstream consumer (command parser or FIFO) and detects per-channel overrun when the consumer stalls.

## Interface
- NUM_CH, 4: number of receiver channels (≥2)
- DATA_BITS, 8: bits per byte, matches the receivers' DATA_BITS
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- i_ch_valid  in  NUM_CH  per-channel byte-valid pulse from each receiver (one cycle per byte)
- i_ch_data  in  NUM_CH*DATA_BITS  channel k's byte at [k*DATA_BITS +: DATA_BITS]
- o_valid  out  1  output byte available
- i_ready  in  1  consumer accepts byte when o_valid & i_ready
- o_data  out  DATA_BITS  output byte
- o_ch_id  out  CH_ID_W  source channel of o_data; CH_ID_W = max(1, $clog2(NUM_CH))
- i_overrun_clr  in  NUM_CH  per-channel sticky overrun clear pulse
- o_overrun  out  NUM_CH  per-channel sticky overrun flag

## Operation
- Holding register per channel (hold_valid[k], hold_data[k]):
  - A cycle with i_ch_valid[k] sets hold_valid[k] and loads hold_data[k].
  - A grant to channel k clears hold_valid[k] unless i_ch_valid[k] is high in the same cycle. In that case the new byte is captured and hold_valid[k] stays 1.
- Overrun: if i_ch_valid[k] is high while hold_valid[k]=1 and channel k is not granted that cycle:
  - The new byte is dropped and the held byte is kept.
  - o_overrun[k] is set (sticky).
- Output stage, two states:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1; o_data and o_ch_id are held stable until accepted.
- Load condition, load = (state==EMPTY) | (o_valid & i_ready):
  - If any hold_valid is set, the granted channel's byte and ID load into the output stage and the state becomes FULL.
  - Otherwise the state becomes EMPTY.
- Round robin:
  - Search starts at (last_grant+1) mod NUM_CH, ascending with wrap.
  - last_grant updates only on a load.
  - Reset value of last_grant is NUM_CH-1, so channel 0 wins first.
- i_overrun_clr[k] clears o_overrun[k]. If a clear and a new overrun coincide, the set wins.
- Reset values:
  - o_valid=0, o_data=0, o_ch_id=0, o_overrun=0.
  - All hold_valid=0, state EMPTY.
  - Reset mid-transfer discards all held and output bytes.

## Timing
- Latency: i_ch_valid in cycle t with the output stage empty and no competing channel gives o_valid=1 in cycle t+2.
- Throughput: one byte per cycle while i_ready=1 and holds are pending.
- Back-to-back accept: with o_valid & i_ready in cycle t, the next pending byte is presented in cycle t+1 with no bubble.
- With i_ready=0, o_valid, o_data and o_ch_id do not change.
- Pending bytes: at most 1 per channel in hold, plus 1 in the output stage.

## Configuration
- UART_RX_ARBITER_OVERRUN_EN:
  - Defined: overrun detection, sticky flags and i_overrun_clr are active as described above.
  - Undefined: o_overrun is tied to 0 and i_overrun_clr is ignored. The drop-new-byte behaviour on a full hold is unchanged.

## Structure
- Shared package uart_pkg holds:
  - the ch_id_width(NUM_CH) function (max(1, clog2));
  - the output-stage state enum (EMPTY, FULL).
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req[NUM_REQ], advance.
  - Outputs: one-hot grant and encoded grant index.
  - It owns the last_grant pointer.

## Test plan
- Single byte: ch2 pulses 0xA5 at t, i_ready=1 -> o_valid high only in t+2, o_data=0xA5, o_ch_id=2.
- Simultaneous: ch0..ch3 pulse 0x10..0x13 in the same cycle, i_ready=1 -> four consecutive output cycles with IDs 0,1,2,3 and data 0x10..0x13.
- Backpressure: i_ready=0, ch1 sends 0x55 then 0x66 -> o_data=0x55 held stable for 10 cycles. On i_ready=1 the bench receives 0x55 then 0x66 on consecutive cycles, and o_overrun=0.
- Overrun: i_ready=0, ch0 sends 0x01, 0x02, 0x03 -> 0x01 in the output stage, 0x02 held, 0x03 dropped, o_overrun[0]=1. Release gives 0x01, 0x02. An i_overrun_clr[0] pulse clears the flag. With the macro undefined, the flag stays 0.
- Fairness: ch0 and ch1 re-pulse every cycle after being granted, i_ready=1 -> output IDs alternate 0,1,0,1, and neither channel overruns.
- Reset mid-operation: assert n_rst while FULL with 2 holds pending -> all outputs 0 at once. After release, no stale bytes appear and the first new ch3 byte outputs with o_ch_id=3.
